mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_step.sv | 35 +++
 rtl/mult_div_ctrl.sv | 143 ++++++++++++++
 tb/tb_mult_div_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default operand width.
package mdu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One unsigned iteration: shift-add for multiply, restoring shift-subtract
// for divide. {hi,lo} is the partial product or {remainder, dividend/quotient}.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic [XLEN-1:0] diff;
    logic            ge;

    assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign shl  = {hi, lo[XLEN-1]};
    // When shl >= m the difference always fits in XLEN bits
    assign ge   = (shl >= {1'b0, m});
    assign diff = shl[XLEN-1:0] - m;

    always_comb begin
        if (is_div) begin
            hi_nxt = ge ? diff : shl[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative multiply/divide controller feeding the HI/LO write paths.
// Define MDU_DIV_ZERO_TRAP_EN to short-cut divide-by-zero with a div_zero pulse.
module mult_div_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out,
    output logic            div_zero
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q;
    logic [XLEN-1:0]   a_q, b_q, m_q, hi_q, lo_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, neg_r_q, bz_q;
    logic              is_div, is_signed, b_zero, sign_a, sign_b;
    logic [XLEN-1:0]   a_mag, b_mag, step_hi, step_lo, fix_hi, fix_lo;
    logic [2*XLEN-1:0] prod_neg;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_DIV) || (op_q == OP_MULT);
    assign b_zero    = (b_q == '0);
    assign sign_a    = is_signed & a_q[XLEN-1];
    assign sign_b    = is_signed & b_q[XLEN-1];
    assign a_mag     = sign_a ? -a_q : a_q;
    assign b_mag     = sign_b ? -b_q : b_q;
    assign prod_neg  = -{hi_q, lo_q};

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div),
        .hi     (hi_q),
        .lo     (lo_q),
        .m      (m_q),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = PREP;
`ifdef MDU_DIV_ZERO_TRAP_EN
            PREP: state_d = (is_div && b_zero) ? DONE : RUN;
`else
            PREP: state_d = RUN;
`endif
            RUN:  if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // Divide by zero bypasses the fix so the raw all-ones / dividend result shows.
    always_comb begin
        fix_hi = hi_q;
        fix_lo = lo_q;
        if (!is_div) begin
            if (neg_q) {fix_hi, fix_lo} = prod_neg;
        end else if (bz_q) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else begin
            if (neg_q)   fix_lo = -lo_q;
            if (neg_r_q) fix_hi = -hi_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            bz_q    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    op_q <= mdu_op_e'(op);
                    a_q  <= operand_a;
                    b_q  <= operand_b;
                end
                PREP: begin
                    m_q     <= is_div ? b_mag : a_mag;
                    lo_q    <= is_div ? a_mag : b_mag;
                    hi_q    <= '0;
                    cnt_q   <= '0;
                    neg_q   <= sign_a ^ sign_b;
                    neg_r_q <= sign_a;
                    bz_q    <= b_zero;
                end
                RUN: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    hi_out <= fix_hi;
                    lo_out <= fix_lo;
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIV_ZERO_TRAP_EN
    logic dz_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                dz_q <= 1'b0;
        else if (state_q == PREP)  dz_q <= is_div && b_zero;
    end
    assign div_zero = (state_q == DONE) && dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed plus random checks of mult_div_ctrl against an arithmetic reference.
// Honours MDU_DIV_ZERO_TRAP_EN the same way the design does.
module tb_mult_div_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] opa = '0, opb = '0;
    logic            busy, done, div_zero;
    logic [XLEN-1:0] hi_out, lo_out;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

`ifdef MDU_DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    mult_div_ctrl #(.XLEN(XLEN)) dut (
        .clock(clk), .reset(rst_n), .start(start), .op(op),
        .operand_a(opa), .operand_b(opb), .busy(busy), .done(done),
        .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint p;
        logic [63:0] u;
        int sq, sr;
        hi = '0; lo = '0;
        case (o)
            2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = p; end
            2'b01: begin u = {32'b0, a} * {32'b0, b}; {hi, lo} = u; end
            default: begin
                if (b == 0) begin
                    lo = '1; hi = a;
                end else if (o == 2'b11) begin
                    lo = a / b; hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 0;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    lo = sq; hi = sr;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); opa = $urandom; opb = $urandom;
    endtask

    // Counts rising edges after the sampling edge until done is seen.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < 200);
    endtask

    task automatic finish_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input int n);
        logic [31:0] mh, ml;
        logic trap_dz;
        trap_dz = TRAP && o[1] && (b == 0);
        check({tag, " latency"}, 64'(n), trap_dz ? 64'd1 : 64'(XLEN + 2));
        check({tag, " done"}, 64'(done), 64'd1);
        if (!trap_dz) begin
            model(o, a, b, mh, ml);
            exp_hi = mh; exp_lo = ml;
        end
        check({tag, " hi"}, 64'(hi_out), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo_out), 64'(exp_lo));
        check({tag, " div_zero"}, 64'(div_zero), 64'(trap_dz));
        @(negedge clk);
        check({tag, " done pulse"}, {62'b0, done, busy}, 64'd0);
        check({tag, " hold"}, {hi_out, lo_out}, {exp_hi, exp_lo});
    endtask

    task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b);
        int n;
        issue(o, a, b);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(0, n);
        finish_check(tag, o, a, b, n);
    endtask

    initial begin
        int n;
        logic [1:0] o;
        logic [31:0] a, b;

        // Reset with start held high must not launch an operation
        start = 1'b1; op = 2'b01; opa = 32'd9; opb = 32'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outs", {busy, done, div_zero, hi_out, lo_out}, 67'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset idle", {62'b0, busy, done}, 64'd0);

        run_check("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu max hi const", 64'(hi_out), 64'hFFFF_FFFE);
        check("multu max lo const", 64'(lo_out), 64'h0000_0001);
        run_check("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        check("mult -3x7 const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_check("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div -7/2 const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_check("divu 100/7", 2'b11, 32'd100, 32'd7);
        check("divu 100/7 const", {hi_out, lo_out}, {32'd2, 32'd14});
        run_check("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div ovf const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        run_check("div 5/0", 2'b10, 32'd5, 32'd0);
        run_check("divu 7/0", 2'b11, 32'd7, 32'd0);
        run_check("div -9/0", 2'b10, 32'hFFFF_FFF7, 32'd0);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 3);
                1: b = -$urandom_range(1, 9);
                default: b = $urandom;
            endcase
            run_check($sformatf("rand%0d", i), o, a, b);
        end

        // Start pulsed mid-operation is ignored
        issue(2'b01, 32'd1234567, 32'd89);
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 2'b10; opa = 32'd77; opb = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(10, n);
        finish_check("ignored start", 2'b01, 32'd1234567, 32'd89, n);
        repeat (3) @(negedge clk);
        check("ignored start idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-multiply
        issue(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset", {busy, done, div_zero, hi_out, lo_out}, 67'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after reset idle", 64'(busy), 64'd0);
        run_check("multu 3x4", 2'b01, 32'd3, 32'd4);
        check("multu 3x4 const", {hi_out, lo_out}, 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
